// File: rtl/shift_rcvr_if.sv
// shift_rcvr_if: serial sample inputs and word handshake of the shift receiver
interface shift_rcvr_if #(
  parameter int SIZE    = 8,
  parameter int IN_SIZE = 1
);
  logic [IN_SIZE-1:0] din;
  logic               se;
  logic               clr;
  logic               ready;
  logic [SIZE-1:0]    dout;
  logic               valid;
  logic               partial;
  logic               overrun;
  modport master (output din, se, clr, ready, input dout, valid, partial, overrun);
  modport slave  (input din, se, clr, ready, output dout, valid, partial, overrun);
endinterface

// File: rtl/shift_rcvr.sv
// shift_rcvr: deserializer with bit counter and valid/ready holding register; SHIFT_RCVR_LSB_FIRST_EN selects LSB-first assembly
module shift_rcvr #(
  parameter int SIZE    = 8,
  parameter int IN_SIZE = 1
) (
  input logic        clk,
  input logic        rst,
  shift_rcvr_if.slave bus
);
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] INC  = CW'(IN_SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - IN_SIZE);
  logic [SIZE-1:0] sr, asm_w;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            done;
  // word including this cycle's sample, completion detect and next count
  always_comb begin
`ifdef SHIFT_RCVR_LSB_FIRST_EN
    asm_w  = {bus.din, sr[SIZE-1:IN_SIZE]};
`else
    asm_w  = {sr[SIZE-IN_SIZE-1:0], bus.din};
`endif
    done   = bus.se && !bus.clr && cnt == LAST;
    cnt_nx = bus.clr ? '0 : !bus.se ? cnt : done ? '0 : cnt + INC;
  end
  // shift/count state, holding register handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      sr          <= '0;
      cnt         <= '0;
      bus.dout    <= '0;
      bus.valid   <= 1'b0;
      bus.overrun <= 1'b0;
      bus.partial <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      bus.partial <= cnt_nx != '0;
      if (bus.clr) sr <= '0;
      else if (bus.se) sr <= asm_w;
      if (bus.clr) bus.overrun <= 1'b0;
      else if (done && bus.valid && !bus.ready) bus.overrun <= 1'b1;
      if (done && (!bus.valid || bus.ready)) begin
        bus.dout  <= asm_w;
        bus.valid <= 1'b1;
      end else if (bus.valid && bus.ready) bus.valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_rcvr.sv
// tb_shift_rcvr: directed checks of shift_rcvr with 1-bit and 4-bit sample widths
module tb_shift_rcvr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  shift_rcvr_if #(.SIZE(8), .IN_SIZE(1)) a ();
  shift_rcvr_if #(.SIZE(8), .IN_SIZE(4)) b ();
  shift_rcvr #(.SIZE(8), .IN_SIZE(1)) u_a (.clk(clk), .rst(rst), .bus(a));
  shift_rcvr #(.SIZE(8), .IN_SIZE(4)) u_b (.clk(clk), .rst(rst), .bus(b));
`ifdef SHIFT_RCVR_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // send raw line values seq[7] first, positions from..to-1 in send order
  task automatic send_raw_a(input logic [7:0] seq, input int from, input int to);
    for (int i = from; i < to; i++) begin
      a.se  = 1'b1;
      a.din = seq[7-i];
      tick();
    end
    a.se = 1'b0;
  endtask
  // send bits so the completed word equals w in the active bit order
  task automatic send_word_a(input logic [7:0] w, input int from, input int to);
    for (int i = from; i < to; i++) begin
      a.se  = 1'b1;
      a.din = LSB ? w[i] : w[7-i];
      tick();
    end
    a.se = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset dout", a.dout, 8'h00);
    chk("reset valid", {7'd0, a.valid}, 8'd0);
    chk("reset overrun", {7'd0, a.overrun}, 8'd0);
    chk("reset partial", {7'd0, a.partial}, 8'd0);
    chk("reset b dout", b.dout, 8'h00);
    chk("reset b valid", {7'd0, b.valid}, 8'd0);
  endtask
  task automatic test_basic();
    logic [7:0] seq;
    seq = 8'b10100101;
    a.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_raw_a(seq, i, i + 1);
      if (i < 7) begin
        if (a.partial !== 1'b1 || a.valid !== 1'b0) begin
          errors++;
          $display("FAIL basic in-progress bit %0d: partial %b valid %b expected 1 0", i, a.partial, a.valid);
        end
        checks++;
      end
    end
    chk("basic dout", a.dout, 8'hA5);
    chk("basic valid", {7'd0, a.valid}, 8'd1);
    chk("basic partial after word", {7'd0, a.partial}, 8'd0);
    tick();
    chk("basic valid consumed", {7'd0, a.valid}, 8'd0);
    chk("basic dout held", a.dout, 8'hA5);
  endtask
  task automatic test_gap();
    b.ready = 1'b1;
    b.se    = 1'b1;
    b.din   = 4'h3;
    tick();
    chk("gap partial first", {7'd0, b.partial}, 8'd1);
    chk("gap valid first", {7'd0, b.valid}, 8'd0);
    b.se  = 1'b0;
    b.din = 4'hF;
    tick();
    tick();
    chk("gap partial hold", {7'd0, b.partial}, 8'd1);
    chk("gap valid hold", {7'd0, b.valid}, 8'd0);
    b.se  = 1'b1;
    b.din = 4'hC;
    tick();
    b.se = 1'b0;
    chk("gap dout", b.dout, LSB ? 8'hC3 : 8'h3C);
    chk("gap valid", {7'd0, b.valid}, 8'd1);
    chk("gap partial done", {7'd0, b.partial}, 8'd0);
    tick();
    chk("gap valid consumed", {7'd0, b.valid}, 8'd0);
  endtask
  task automatic test_overrun();
    a.ready = 1'b0;
    send_word_a(8'h11, 0, 8);
    chk("ovr first dout", a.dout, 8'h11);
    chk("ovr first overrun", {7'd0, a.overrun}, 8'd0);
    send_word_a(8'h22, 0, 8);
    chk("ovr dout kept", a.dout, 8'h11);
    chk("ovr valid", {7'd0, a.valid}, 8'd1);
    chk("ovr overrun set", {7'd0, a.overrun}, 8'd1);
    a.ready = 1'b1;
    tick();
    a.ready = 1'b0;
    chk("ovr valid consumed", {7'd0, a.valid}, 8'd0);
    chk("ovr overrun sticky", {7'd0, a.overrun}, 8'd1);
    a.clr = 1'b1;
    tick();
    a.clr = 1'b0;
    chk("ovr cleared by clr", {7'd0, a.overrun}, 8'd0);
  endtask
  task automatic test_back_to_back();
    a.ready = 1'b1;
    send_word_a(8'h5A, 0, 8);
    chk("b2b first dout", a.dout, 8'h5A);
    chk("b2b first valid", {7'd0, a.valid}, 8'd1);
    a.ready = 1'b0;
    send_word_a(8'hC3, 0, 7);
    chk("b2b hold dout", a.dout, 8'h5A);
    a.ready = 1'b1;
    send_word_a(8'hC3, 7, 8);
    chk("b2b second dout", a.dout, 8'hC3);
    chk("b2b valid across", {7'd0, a.valid}, 8'd1);
    chk("b2b no overrun", {7'd0, a.overrun}, 8'd0);
    tick();
    chk("b2b valid consumed", {7'd0, a.valid}, 8'd0);
  endtask
  task automatic test_clr_midword();
    a.ready = 1'b1;
    send_word_a(8'hFF, 0, 5);
    chk("clr partial before", {7'd0, a.partial}, 8'd1);
    a.clr = 1'b1;
    a.se  = 1'b1;
    a.din = 1'b1;
    tick();
    a.clr = 1'b0;
    a.se  = 1'b0;
    chk("clr partial after", {7'd0, a.partial}, 8'd0);
    chk("clr valid untouched", {7'd0, a.valid}, 8'd0);
    send_word_a(8'h81, 0, 8);
    chk("clr clean word", a.dout, 8'h81);
    chk("clr valid", {7'd0, a.valid}, 8'd1);
  endtask
  task automatic test_rst_midword();
    a.ready = 1'b0;
    send_word_a(8'hFF, 0, 8);
    send_word_a(8'hFF, 0, 3);
    chk("rst pre overrun", {7'd0, a.overrun}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst dout", a.dout, 8'h00);
    chk("rst valid", {7'd0, a.valid}, 8'd0);
    chk("rst partial", {7'd0, a.partial}, 8'd0);
    chk("rst overrun", {7'd0, a.overrun}, 8'd0);
    a.ready = 1'b1;
    send_word_a(8'h96, 0, 8);
    chk("rst next word", a.dout, 8'h96);
  endtask
  task automatic test_bit_order();
    a.ready = 1'b1;
    tick();
    send_raw_a(8'b11000000, 0, 8);
    chk("order 1,1,0,0,0,0,0,0", a.dout, LSB ? 8'h03 : 8'hC0);
    send_raw_a(8'b10100101, 0, 8);
    chk("order 1,0,1,0,0,1,0,1", a.dout, 8'hA5);
  endtask
  initial begin
    a.din = '0; a.se = 1'b0; a.clr = 1'b0; a.ready = 1'b0;
    b.din = '0; b.se = 1'b0; b.clr = 1'b0; b.ready = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_overrun();
    test_back_to_back();
    test_clr_midword();
    test_rst_midword();
    test_bit_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
